tvbg_run_sequencer: RTL
=======================

# tvbg_run_sequencer

Run sequencer for the TV-B-Gone core. It debounces the user button and issues start pulses to `tv_b_gone`. It supervises the core's busy/fail handshake and repeats the full code sweep a parameterised number of passes, with a programmable quiet gap between passes. It sits between the board button/LEDs and the `tv_b_gone` instance, and also drives that instance's synchronous reset.

## Interface
- `DEBOUNCE_CYCLES`, default 65536: number of consecutive stable synchronized samples needed to accept a button level change; legal range 2..2^20.
- `GAP_CYCLES`, default 1000000: idle cycles between the end of one pass and the next start; legal range 1..2^24.
- `PASSES`, default 2: complete sweeps per button press; legal range 1..255.
- `BUSY_TIMEOUT`, default 64: maximum number of cycles from `start_out` to `busy_in` high; legal range 2..255.

Ports:
- `clock_in`, input, 1 bit: clock.
- `reset_in`, input, 1 bit: asynchronous, active-low reset.
- `button_in`, input, 1 bit: raw button, active high, asynchronous to `clock_in`.
- `busy_in`, input, 1 bit: from `tv_b_gone` `busy_out`.
- `fail_in`, input, 1 bit: from `tv_b_gone` `fail_out`.
- `start_out`, output, 1 bit: to `tv_b_gone` `start_in`; one-cycle pulse.
- `core_reset_out`, output, 1 bit: to `tv_b_gone` `reset_in`; one-cycle active-high pulse.
- `busy_out`, output, 1 bit: sequence in progress.
- `done_out`, output, 1 bit: one-cycle pulse when all passes completed.
- `error_out`, output, 1 bit: sticky error indicator.
- `pass_count_out`, output, 8 bits: number of passes completed in the current or last sequence.

## Operation
- **Button input path**
  - `button_in` goes through a 2-flop synchronizer.
  - The debounce counter resets whenever the synchronized level differs from the previous synchronized sample.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, the debounced level takes the synchronized value.
  - `press` is a one-cycle internal event on each 0->1 edge of the debounced level.
- **States:** IDLE, START, WAIT_BUSY, RUN, GAP, DONE, ERROR. All outputs are registered (Moore).
- **IDLE**
  - `press` -> START; clear `pass_count_out` to 0.
- **START**
  - `start_out`=1 for exactly this cycle.
  - -> WAIT_BUSY; clear the timeout counter.
- **WAIT_BUSY**
  - `fail_in` -> ERROR.
  - Else `busy_in` -> RUN.
  - Else, if the timeout counter reaches `BUSY_TIMEOUT-1` -> ERROR.
- **RUN**
  - `fail_in` -> ERROR. This has priority over `busy_in` falling in the same cycle.
  - `busy_in`=0 -> increment `pass_count_out`.
    - If the new count equals `PASSES` -> DONE.
    - Otherwise -> GAP; clear the gap counter.
- **GAP**
  - The gap counter counts up; at `GAP_CYCLES-1` -> START.
  - `fail_in` in GAP -> ERROR.
- **DONE**
  - `done_out`=1 for this single cycle, then -> IDLE.
- **ERROR**
  - On entry, `core_reset_out`=1 for the first cycle in ERROR only.
  - `error_out` is held at 1 while in ERROR.
  - `press` -> IDLE and clears `error_out`. This press does not start a sequence; a new press is needed.
- **Button presses outside IDLE/ERROR**
  - Ignored, unless the abort feature is compiled in (see Configuration).
- **`busy_out` definition**
  - `busy_out`=1 in START, WAIT_BUSY, RUN and GAP; 0 otherwise.
- **Counter behaviour**
  - `pass_count_out` holds its value through IDLE until the next sequence starts.
  - `pass_count_out` never wraps, because `PASSES` is at most 255.
- **Counter widths**
  - Each counter is sized with $clog2 of its parameter.
  - Comparisons use the full counter width; no truncation.

## Timing
- **Reset values**
  - While `reset_in`=0: state IDLE; synchronizer flops, debounced level and all counters 0; every output 0.
  - Reset takes effect asynchronously. Deassertion is sampled on the next `clock_in` rising edge.
- **Press latency**
  - A clean `button_in` rise produces `press` 2 (synchronizer) + `DEBOUNCE_CYCLES` cycles later.
  - `start_out` is high in the cycle after `press`.
- **Gap timing:** from the cycle in which `busy_in` is seen low in RUN, the next `start_out` follows exactly `GAP_CYCLES`+2 cycles later.
- **`done_out` timing:** `done_out` is high in the cycle after the final `busy_in` fall is sampled.
- **Timeout:** with `busy_in` held low, ERROR is entered `BUSY_TIMEOUT` cycles after the START cycle.
- **Reset mid-sequence:** the block returns to IDLE immediately, and no `core_reset_out` pulse is issued. The system reset covers the core.

## Configuration
- **`TVBG_SEQ_ABORT_EN` defined**
  - A `press` in START, WAIT_BUSY, RUN or GAP aborts the sequence.
  - The block goes -> IDLE, with `core_reset_out`=1 for one cycle in the cycle after the press.
  - `pass_count_out` is held; `done_out` is not pulsed.
  - If `fail_in` and `press` occur in the same cycle, `fail_in` wins -> ERROR.
- **`TVBG_SEQ_ABORT_EN` not defined**
  - Presses outside IDLE/ERROR are ignored.
  - `core_reset_out` pulses only on ERROR entry.

## Test plan
- **Basic two-pass run**
  - Setup: `DEBOUNCE_CYCLES`=4, `GAP_CYCLES`=10, `PASSES`=2.
  - Stimulus: clean press; model `busy_in` high 2 cycles after each `start_out`, for 50 cycles.
  - Required response: 2 `start_out` pulses, 12 cycles apart from the first `busy_in` fall to the second `start_out`; one `done_out`; `pass_count_out`=2.
- **Bounce rejection**
  - Stimulus: 3-cycle glitches on `button_in`, with `DEBOUNCE_CYCLES`=4.
  - Required response: no `start_out`.
  - Follow-up: a 6-cycle stable press gives exactly one `start_out`.
- **Busy timeout**
  - Stimulus: `BUSY_TIMEOUT`=8; `busy_in` never rises.
  - Required response: `error_out`=1 and a one-cycle `core_reset_out` 8 cycles after START.
  - Follow-up: the next press clears `error_out` without a `start_out`.
- **Fail priority**
  - Stimulus: `fail_in`=1 in the same cycle as the `busy_in` fall in RUN.
  - Required response: ERROR; `pass_count_out` unchanged; no `done_out`.
- **Abort** (with `TVBG_SEQ_ABORT_EN`)
  - Stimulus: press during GAP.
  - Required response: `core_reset_out` pulse; IDLE; `busy_out`=0.
  - Without the macro: the same press is ignored and the sequence completes.
- **Async reset during RUN**
  - Stimulus: assert `reset_in` low during RUN.
  - Required response: all outputs 0 with no clock edge; after release, IDLE and a fresh press starts from `pass_count_out`=0.

Source files
------------

// File: rtl/tvbg_run_sequencer.sv
// Run sequencer for the TV-B-Gone core: button debounce, start/busy/fail supervision, multi-pass
// sweeps with a quiet gap. Optional press-to-abort is compiled in with TVBG_SEQ_ABORT_EN.
module tvbg_run_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned GAP_CYCLES      = 1000000,
  parameter int unsigned PASSES          = 2,
  parameter int unsigned BUSY_TIMEOUT    = 64
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       button_in,
  input  logic       busy_in,
  input  logic       fail_in,
  output logic       start_out,
  output logic       core_reset_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out,
  output logic [7:0] pass_count_out
);

`ifdef TVBG_SEQ_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  localparam int unsigned DbW  = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GapW = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToW  = ($clog2(BUSY_TIMEOUT) > 0) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast    = GapW'(GAP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast     = ToW'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]      PassTarget = 8'(PASSES);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StRun,
    StGap,
    StDone,
    StError
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Button synchronizer and debounce
  // ---------------------------------------------------------------------------------------------
  logic           sync1_q, sync2_q, sync_prev_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           deb_q, deb_d;
  logic           press;

  always_comb begin
    db_cnt_d = db_cnt_q;
    deb_d    = deb_q;
    if (sync2_q != sync_prev_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      deb_d = sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign press = deb_d & ~deb_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      db_cnt_q    <= '0;
      deb_q       <= 1'b0;
    end else begin
      sync1_q     <= button_in;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      db_cnt_q    <= db_cnt_d;
      deb_q       <= deb_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [7:0]      pass_q, pass_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            gap_hit_q, gap_hit_d;
  logic            abort;
  logic            start_q, start_d;
  logic            core_reset_q, core_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gap_hit_d = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StStart;
          pass_d  = '0;
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StWaitBusy;
      end
      StWaitBusy: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (fail_in) begin
          state_d = StError;
        end else if (busy_in) begin
          state_d = StRun;
        end else if (to_cnt_d == ToLast) begin
          state_d = StError;
        end
      end
      StRun: begin
        if (fail_in) begin
          state_d = StError;
        end else if (!busy_in) begin
          pass_d = pass_q + 8'd1;
          if (pass_d == PassTarget) begin
            state_d = StDone;
          end else begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end
        end
      end
      StGap: begin
        // The terminal count is registered, so the gap spans one cycle past GAP_CYCLES.
        if (gap_cnt_q != GapLast) begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
        gap_hit_d = (gap_cnt_q == GapLast) && !gap_hit_q;
        if (fail_in) begin
          state_d = StError;
        end else if (gap_hit_q) begin
          state_d = StStart;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        if (press) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (AbortEn && press && (state_q inside {StStart, StWaitBusy, StRun, StGap})) begin
      if (fail_in) begin
        state_d = StError;
      end else begin
        state_d = StIdle;
        pass_d  = pass_q;
        abort   = 1'b1;
      end
    end
  end

  always_comb begin
    start_d      = (state_d == StStart);
    busy_d       = (state_d inside {StStart, StWaitBusy, StRun, StGap});
    done_d       = (state_d == StDone);
    error_d      = (state_d == StError);
    core_reset_d = ((state_d == StError) && (state_q != StError)) || abort;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= StIdle;
      pass_q       <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      gap_hit_q    <= 1'b0;
      start_q      <= 1'b0;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_hit_q    <= gap_hit_d;
      start_q      <= start_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign start_out      = start_q;
  assign core_reset_out = core_reset_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = error_q;
  assign pass_count_out = pass_q;

endmodule
